muldiv_iter: RTL and testbench

Iterative multiply/divide unit implementing the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a configurable data width. It sits beside the core ALU as a multi-cycle execution unit. The core issues one operation through a valid/ready handshake and receives the result, with a destination tag, through a second valid/ready handshake. One radix-2 step per cycle keeps area small, and a flush input lets the core abort an in-flight operation.

---
 rtl/muldiv_iter.sv | 241 ++++++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative RV32M multiply/divide unit. One radix-2 step per
//               cycle on operand magnitudes, followed by a single sign-fix
//               cycle. Valid/ready handshake on both the request and the
//               result side, with a pass-through destination tag and a
//               synchronous flush that aborts the operation in flight.
// Ports       : clk, reset        - rising-edge clock, async active-high reset
//               flush_i           - abort the current operation
//               in_valid_i/in_ready_o, op_i, a_i, b_i, tag_in_i - request
//               out_valid_o/out_ready_i, result_o, tag_out_o,
//               div_zero_o        - response
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [TAGW-1:0]  tag_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [TAGW-1:0]  tag_out_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opa_q, opa_d;       // |a|; shifts left during divide
    logic [WIDTH-1:0]   opb_q, opb_d;       // |b|; shifts left during multiply
    logic               neg_q_q, neg_q_d;   // product / quotient must be negated
    logic               neg_r_q, neg_r_d;   // remainder must be negated
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAGW-1:0]    tag_out_q, tag_out_d;
    logic               div_zero_q, div_zero_d;

    // ------------------------------------------------------------------
    // Accept-time decode: signedness, magnitudes and special cases
    // ------------------------------------------------------------------
    logic             w_a_signed, w_b_signed, w_sa, w_sb;
    logic [WIDTH-1:0] w_a_abs, w_b_abs;
    logic             w_div_zero, w_ovf, w_special;
    logic [WIDTH-1:0] w_special_res;

    assign w_a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                        (op_i == OP_DIV)  || (op_i == OP_REM);
    assign w_b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_sa       = w_a_signed & a_i[WIDTH-1];
    assign w_sb       = w_b_signed & b_i[WIDTH-1];
    // Negating the most-negative value yields the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    assign w_a_abs    = w_sa ? -a_i : a_i;
    assign w_b_abs    = w_sb ? -b_i : b_i;

    assign w_div_zero = op_i[2] && (b_i == '0);
    assign w_ovf      = op_i[2] && !op_i[0] &&
                        (a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (b_i == '1);
    assign w_special  = w_div_zero || w_ovf;

    // op_i[1] selects remainder within the divide group
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op_i[1] ? a_i : '1;
        end else begin
            w_special_res = op_i[1] ? '0 : a_i;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Multiply scans the multiplier MSB first, so the accumulator doubles
    // each step before the conditional add.
    logic [2*WIDTH-1:0] w_mul_acc;
    assign w_mul_acc = {acc_q[2*WIDTH-2:0], 1'b0} +
                       (opb_q[WIDTH-1] ? {{WIDTH{1'b0}}, opa_q} : {(2*WIDTH){1'b0}});

    // Restoring divide: high half is the partial remainder, low half
    // collects quotient bits. The shifted remainder is below 2*|b|, so
    // the trial difference's top bit is a clean borrow flag.
    logic [WIDTH:0]     w_rem_sh, w_trial;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_div_acc;
    assign w_rem_sh  = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, opb_q};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_div_acc = {(w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], w_qbit};

    // Sign correction and result selection
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_fix_res;
    assign w_prod = neg_q_q ? -acc_q : acc_q;
    assign w_quo  = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign w_rem  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_res = '0;
        case (op_q)
            OP_MUL:                       w_fix_res = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_fix_res = w_quo;
            OP_REM, OP_REMU:              w_fix_res = w_rem;
            default:                      w_fix_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        tag_out_d  = tag_out_q;
        div_zero_d = div_zero_q;

        case (state_q)
            S_IDLE: begin
                // A flush in the accept cycle wins: nothing is latched.
                if (in_valid_i && !flush_i) begin
                    op_d      = op_i;
                    tag_out_d = tag_in_i;
                    opa_d     = w_a_abs;
                    opb_d     = w_b_abs;
                    neg_q_d   = w_sa ^ w_sb;
                    neg_r_d   = w_sa;
                    acc_d     = '0;
                    cnt_d     = CW'(WIDTH);
                    if (w_special) begin
                        result_d   = w_special_res;
                        div_zero_d = w_div_zero;
                        state_d    = S_DONE;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (op_q[2]) begin
                    acc_d = w_div_acc;
                    opa_d = opa_q << 1;
                end else begin
                    acc_d = w_mul_acc;
                    opb_d = opb_q << 1;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = w_fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            tag_out_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            tag_out_q  <= tag_out_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
    assign tag_out_o   = tag_out_q;
    assign div_zero_o  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_iter
// Description : Self-checking bench for muldiv_iter (WIDTH=32, TAGW=5).
//               Table of directed vectors plus hand-written flush and
//               asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam int LAT_NORM = 33;  // edges from accept to out_valid
    localparam int LAT_SPEC = 0;   // valid straight after the accepting edge

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  tag_out;
    logic        div_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(32), .TAGW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .tag_in_i    (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_out_o   (tag_out),
        .div_zero_o  (div_zero)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          bp;    // cycles of backpressure held in DONE
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int n;
        logic busy_ok;
        logic stable_ok;
        @(negedge clk);
        check($sformatf("v%0d ready_before", idx), {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op       = v.op;
        a        = v.a;
        b        = v.b;
        tag_in   = v.tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands are only sampled at accept; scramble them now.
        a        = ~v.a;
        b        = v.b ^ 32'h5A5A_A5A5;
        tag_in   = ~v.tag;
        n        = 0;
        busy_ok  = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
        check($sformatf("v%0d ready_low_busy", idx), {63'd0, busy_ok & ~in_ready}, 64'd1);
        check($sformatf("v%0d result", idx), {32'd0, result}, {32'd0, v.res});
        check($sformatf("v%0d tag", idx), {59'd0, tag_out}, {59'd0, v.tag});
        check($sformatf("v%0d div_zero", idx), {63'd0, div_zero}, {63'd0, v.dz});
        if (v.bp > 0) begin
            stable_ok = 1'b1;
            for (int k = 0; k < v.bp; k++) begin
                @(negedge clk);
                in_valid = 1'b1;
                op       = OP_MUL;
                a        = 32'd1;
                b        = 32'd1;
                tag_in   = 5'd31;
                @(posedge clk);
                #1;
                if (!out_valid || in_ready || result !== v.res ||
                    tag_out !== v.tag || div_zero !== v.dz) stable_ok = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("v%0d backpressure_hold", idx), {63'd0, stable_ok}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d handshake_idle", idx), {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        vec_t hv;
        logic seen;

        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 1'b0, LAT_NORM, 0};
        vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0, LAT_NORM, 0};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 1'b0, LAT_NORM, 0};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 1'b0, LAT_NORM, 0};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 1'b0, LAT_NORM, 0};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFF, 1'b0, LAT_NORM, 0};
        vecs[6]  = '{OP_DIVU,   32'hFFFF_FFF9,  32'd2,         5'd6,  32'h7FFF_FFFC, 1'b0, LAT_NORM, 0};
        vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         5'd7,  32'd2,         1'b0, LAT_NORM, 0};
        vecs[8]  = '{OP_DIVU,   32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF, 1'b1, LAT_SPEC, 0};
        vecs[9]  = '{OP_REM,    32'd5,          32'd0,         5'd10, 32'd5,         1'b1, LAT_SPEC, 0};
        vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0, LAT_SPEC, 0};
        vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1'b0, LAT_SPEC, 0};
        vecs[12] = '{OP_DIV,    32'd20,         32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFFA, 1'b0, LAT_NORM, 5};
        vecs[13] = '{OP_REM,    32'd20,         32'hFFFF_FFFD, 5'd14, 32'd2,         1'b0, LAT_NORM, 0};
        vecs[14] = '{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd15, 32'd1,         1'b0, LAT_NORM, 0};

        // Reset state
        #12;
        check("reset in_ready",  {63'd0, in_ready},  64'd1);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset result",    {32'd0, result},    64'd0);
        check("reset tag_out",   {59'd0, tag_out},   64'd0);
        check("reset div_zero",  {63'd0, div_zero},  64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], i);
        end

        // Flush at CALC step 10
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_MUL;
        a        = 32'd5;
        b        = 32'd6;
        tag_in   = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush idle", {62'd0, out_valid, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush no_valid", {63'd0, seen}, 64'd0);
        hv = '{OP_MUL, 32'd3, 32'd4, 5'd20, 32'd12, 1'b0, LAT_NORM, 0};
        run_op(hv, 100);

        // Asynchronous reset mid-CALC; result (12) and tag (21) are nonzero
        @(negedge clk);
        in_valid = 1'b1;
        op       = OP_DIVU;
        a        = 32'd99;
        b        = 32'd9;
        tag_in   = 5'd21;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("areset in_ready",  {63'd0, in_ready},  64'd1);
        check("areset out_valid", {63'd0, out_valid}, 64'd0);
        check("areset result",    {32'd0, result},    64'd0);
        check("areset tag_out",   {59'd0, tag_out},   64'd0);
        check("areset div_zero",  {63'd0, div_zero},  64'd0);
        @(negedge clk);
        reset = 1'b0;
        hv = '{OP_DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 1'b0, LAT_NORM, 0};
        run_op(hv, 101);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
